prefetch_unit: RTL
==================

# prefetch_unit

Parametrised instruction prefetch and variable-length extraction unit for the PISA core family, replacing the fixed FETCH/FETCH_IMM/FETCH_IMEM state sequence. It streams aligned bus words into a byte queue using a req/ack memory handshake that tolerates wait states. It extracts one decoded-length instruction per valid/ready transfer and flushes on redirect.

## Interface
- BUS_BYTES, 4: memory data width in bytes; power of two, 1..8.
- QUEUE_BYTES, 16: byte-queue depth; power of two, at least max(10, 2*BUS_BYTES).
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- mode  in  2  data-size mode: 00 byte, 01 half, 1x word.
- mem_req  out  1  fetch request; held until mem_ack.
- mem_addr  out  32  fetch address, BUS_BYTES-aligned.
- mem_ack  in  1  rdata valid; may assert in the same cycle as mem_req.
- mem_rdata  in  8*BUS_BYTES  little-endian fetch data.
- redirect  in  1  flush and restart at redirect_pc.
- redirect_pc  in  32  new PC; any byte alignment.
- inst_valid  out  1  head instruction complete.
- inst_ready  in  1  consumer accepts.
- inst_pc  out  32  address of the opcode byte.
- inst_len  out  4  instruction length in bytes, 1..10.
- inst_opcode  out  8  byte 0.
- inst_rs1 / inst_rs2  out  3 each  byte1[6:4] / byte1[2:0]; 0 when there is no register byte.
- inst_imm  out  32  zero-extended little-endian immediate; 0 if absent.
- inst_imem  out  32  little-endian memory operand; 0 if absent.
- inst_illegal  out  1  opcode type 111.

## Operation
- The opcode type t is op[7:5].
- Length is 1 + t[2] + (t[0] ? ib : 0) + (t[1] ? 4 : 0), where ib = 1 / 2 / 4 for mode 00 / 01 / 1x.
- t=111 gives length 1 with inst_illegal=1.
- Byte order: opcode, register byte (if t[2]), immediate (if t[0]), imem (if t[1]).
- inst_valid = (count >= len(head)). Fields are driven combinationally from the queue head.
- Fire = inst_valid && inst_ready. On fire, pop inst_len bytes, and inst_pc += inst_len (mod 2^32).
- Fetch FSM states:
  - IDLE: go to REQ when free space (QUEUE_BYTES - count) >= BUS_BYTES and no redirect is present.
  - REQ: mem_req=1, mem_addr=fetch_addr. On ack, push bytes [fetch_offset .. BUS_BYTES-1], set fetch_addr += BUS_BYTES, clear fetch_offset, go to IDLE.
  - DROP: mem_req=1 at the old address. On ack, discard the data and go to IDLE.
- Redirect:
  - Flushes the queue (count=0) and sets inst_pc=redirect_pc.
  - Sets fetch_addr=redirect_pc aligned down and fetch_offset=redirect_pc mod BUS_BYTES.
  - REQ without ack goes to DROP; the request is never withdrawn.
- Simultaneous events:
  - Redirect with fire: redirect wins; the pop and PC advance are discarded.
  - Redirect with ack: the data is discarded, the FSM goes to IDLE, and mem_req is deasserted.
  - Redirect in DROP: stays in DROP and updates the target.
- Queue is full (free < BUS_BYTES): no request is issued. Pointers wrap modulo QUEUE_BYTES.
- Pop and push in the same cycle: count = count - len + pushed.
- mode must be held stable while inst_valid=1. A change takes effect on the next head evaluation.
- Reset:
  - Outputs: mem_req=0, mem_addr=0, inst_valid=0, inst_pc=0, count=0, FSM=IDLE.
  - A request abandoned by reset mid-operation is discarded; the slave shares rst.
  - Fetch from address 0 starts the cycle after rst deasserts.

## Timing
- Registered: mem_req, mem_addr, queue, pointers, and inst_pc.
- Combinational: inst_* decode from the queue head and mode.
- Redirect sampled at edge N: mem_req asserts in cycle N+1.
- With zero-wait ack, inst_valid asserts at the earliest in cycle N+2.
- Each wait cycle adds one cycle.
- Steady state with zero-wait memory: one bus word per 2 cycles (REQ, IDLE).
- Throughput is one instruction per cycle while the queue holds enough bytes.
- inst_* are stable while inst_valid && !inst_ready, except on redirect.

## Configuration
- PREFETCH_STALL_COUNT_EN defined:
  - Adds output stall_cycles[31:0], reset 0.
  - Increments (wrapping) each cycle where inst_ready=1 and inst_valid=0 and redirect=0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Opcode type 000 for data byte 0x05 and opcode type 100 for 0x85; with mode=00, mem returns bytes 05 85 31 xx at addr 0 with ack on the first req cycle → first instruction len 1, pc 0; second len 2, rs1=3, rs2=1, pc 1.
- mode=01, opcode type 101 (0xA5), register byte 0x42, immediate bytes 34 12 → len 4, imm=0x00001234, rs1=4, rs2=2.
- Opcode type 111 (0xE0) and opcode type 111 (0xFF) → illegal=1, len=1, pc advances by 1.
- Redirect to 0x103 with BUS_BYTES=4 while a REQ at 0x10 is held 3 wait cycles → DROP, old data discarded, next mem_addr=0x100, first inst_pc=0x103 with only byte 3 pushed.
- inst_ready=0 for 20 cycles with zero-wait memory → count saturates at QUEUE_BYTES - (QUEUE_BYTES mod BUS_BYTES), mem_req stays low, fields hold stable; stall_cycles unchanged.
- Redirect, fire and ack in the same cycle, then rst asserted mid-REQ → queue empty with inst_pc=redirect_pc; after reset, mem_req=0 and inst_pc=0, and the next mem_req is at 0.

Source files
------------

// File: rtl/prefetch_unit.sv
// prefetch_unit: streams aligned bus words into a byte queue and hands out
// one variable-length PISA instruction per valid/ready transfer.
// Optional feature macro: PREFETCH_STALL_COUNT_EN adds the stall_cycles
// counter output (consumer ready but no instruction available).
module prefetch_unit #(
  parameter int BUS_BYTES   = 4,
  parameter int QUEUE_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [8*BUS_BYTES-1:0] mem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst_pc,
  output logic [3:0]             inst_len,
  output logic [7:0]             inst_opcode,
  output logic [2:0]             inst_rs1,
  output logic [2:0]             inst_rs2,
  output logic [31:0]            inst_imm,
  output logic [31:0]            inst_imem,
  output logic                   inst_illegal
`ifdef PREFETCH_STALL_COUNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int QW = $clog2(QUEUE_BYTES);
  localparam int CW = QW + 1;
  localparam int OW = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [7:0]    queue [QUEUE_BYTES];
  logic [7:0]    head  [16];
  logic [QW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free_n, push_n;
  logic [31:0]   fetch_addr;
  logic [OW-1:0] fetch_offset;
  logic          push_en, fire, pop_en;
  logic [2:0]    op_type;
  logic [2:0]    ib;
  logic [3:0]    imm_pos, imem_pos;

  assign free_n = CW'(QUEUE_BYTES) - count;
  assign push_n = CW'(BUS_BYTES) - CW'(fetch_offset);
  assign fire   = inst_valid && inst_ready;
  assign pop_en = fire && !redirect;

  // Fetch FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Fetch FSM next state; a redirect never withdraws an outstanding request
  always_comb begin
    state_next = state;
    push_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!redirect && (free_n >= CW'(BUS_BYTES))) state_next = S_REQ;
      end
      S_REQ: begin
        if (mem_ack) begin
          state_next = S_IDLE;
          push_en    = !redirect;
        end else if (redirect) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered bus request; address only latched when a new request starts
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_req <= (state_next == S_REQ) || (state_next == S_DROP);
      if ((state == S_IDLE) && (state_next == S_REQ)) mem_addr <= fetch_addr;
    end
  end

  // Queue storage: only bytes from fetch_offset upward of the word are kept
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < BUS_BYTES; i++) begin
        if (OW'(i) >= fetch_offset)
          queue[wr_ptr + QW'(i) - QW'(fetch_offset)] <= mem_rdata[8*i +: 8];
      end
    end
  end

  // Queue pointers and occupancy; redirect flushes and beats any pop
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + (push_en ? QW'(push_n) : QW'(0));
      rd_ptr <= rd_ptr + (pop_en ? QW'(inst_len) : QW'(0));
      count  <= count + (push_en ? push_n : CW'(0)) - (pop_en ? CW'(inst_len) : CW'(0));
    end
  end

  // Fetch pointer and instruction PC tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr   <= '0;
      fetch_offset <= '0;
      inst_pc      <= '0;
    end else if (redirect) begin
      fetch_addr   <= redirect_pc & ~32'(BUS_BYTES - 1);
      fetch_offset <= OW'(redirect_pc % 32'(BUS_BYTES));
      inst_pc      <= redirect_pc;
    end else begin
      if (push_en) begin
        fetch_addr   <= fetch_addr + 32'(BUS_BYTES);
        fetch_offset <= '0;
      end
      if (pop_en) inst_pc <= inst_pc + 32'(inst_len);
    end
  end

  // Window of bytes starting at the queue head, wrapping around the queue
  always_comb begin
    for (int i = 0; i < 16; i++) head[i] = queue[rd_ptr + QW'(i)];
  end

  // Decode length and fields of the head instruction under the current mode
  always_comb begin
    op_type      = head[0][7:5];
    inst_opcode  = head[0];
    inst_illegal = (op_type == 3'b111);
    case (mode)
      2'b00:   ib = 3'd1;
      2'b01:   ib = 3'd2;
      default: ib = 3'd4;
    endcase
    imm_pos   = 4'd1 + {3'b000, op_type[2]};
    imem_pos  = imm_pos + (op_type[0] ? {1'b0, ib} : 4'd0);
    inst_len  = 4'd1;
    inst_rs1  = '0;
    inst_rs2  = '0;
    inst_imm  = '0;
    inst_imem = '0;
    if (!inst_illegal) begin
      inst_len = imem_pos + (op_type[1] ? 4'd4 : 4'd0);
      if (op_type[2]) begin
        inst_rs1 = head[1][6:4];
        inst_rs2 = head[1][2:0];
      end
      if (op_type[0]) begin
        for (int k = 0; k < 4; k++)
          if (k < int'(ib)) inst_imm[8*k +: 8] = head[imm_pos + 4'(k)];
      end
      if (op_type[1]) begin
        for (int k = 0; k < 4; k++) inst_imem[8*k +: 8] = head[imem_pos + 4'(k)];
      end
    end
    inst_valid = (count != '0) && (count >= CW'(inst_len));
  end

`ifdef PREFETCH_STALL_COUNT_EN
  // Count cycles the consumer waited on an empty or partial head
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (inst_ready && !inst_valid && !redirect) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
